// File: rtl/factorial_seq_unit.sv
// factorial_seq_unit: multi-cycle 64-bit factorial engine.
// It performs one multiply per cycle and uses valid/ready handshakes on both the operand and result sides.
// If the product overflows OUT_W bits, the result saturates to all-ones and out_ovf is set.
// Optional feature: define FACT_ABORT_EN to add an 'abort' input that cancels an operation while it is in CALC.
module factorial_seq_unit #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_result,
  output logic             out_ovf
`ifdef FACT_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state, state_nx;
  logic [IN_W-1:0]    n_q, n_nx;
  logic [IN_W-1:0]    cnt_q, cnt_nx;
  logic [OUT_W-1:0]   acc_q, acc_nx;
  logic [OUT_W-1:0]   res_q, res_nx;
  logic               ovf_q, ovf_nx;
  logic [2*OUT_W-1:0] prod;
  logic               abort_req;

`ifdef FACT_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Full-width product; any nonzero upper half means n! no longer fits
  assign prod = (2*OUT_W)'(acc_q) * (2*OUT_W)'(cnt_q);

  assign out_result = res_q;
  assign out_ovf    = ovf_q;

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_q   <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      n_q   <= n_nx;
      cnt_q <= cnt_nx;
      acc_q <= acc_nx;
      res_q <= res_nx;
      ovf_q <= ovf_nx;
    end
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_nx  = state;
    n_nx      = n_q;
    cnt_nx    = cnt_q;
    acc_nx    = acc_q;
    res_nx    = res_q;
    ovf_nx    = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          n_nx   = in_n;
          acc_nx = OUT_W'(1);
          cnt_nx = IN_W'(2);
          if (in_n <= IN_W'(1)) begin
            res_nx   = OUT_W'(1);
            ovf_nx   = 1'b0;
            state_nx = DONE;
          end else begin
            state_nx = CALC;
          end
        end
      end
      CALC: begin
        if (abort_req) begin
          state_nx = IDLE;
        end else if (prod[2*OUT_W-1:OUT_W] != '0) begin
          res_nx   = '1;
          ovf_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          acc_nx = prod[OUT_W-1:0];
          if (cnt_q == n_q) begin
            res_nx   = prod[OUT_W-1:0];
            ovf_nx   = 1'b0;
            state_nx = DONE;
          end else begin
            cnt_nx = cnt_q + IN_W'(1);
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_factorial_seq_unit.sv
// Directed self-checking bench for factorial_seq_unit.
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled at that same point.
// Latency is counted as the number of rising edges after the accept edge until out_valid is seen.
// For n<=1 this count is 0, because the result is already valid in the first cycle after the accept.
module tb_factorial_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_n;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_ovf;
`ifdef FACT_ABORT_EN
  logic        abort;
`endif

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  factorial_seq_unit #(.IN_W(32), .OUT_W(64)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_n(in_n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_ovf(out_ovf)
`ifdef FACT_ABORT_EN
    ,
    .abort(abort)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present n for one cycle, then count the edges until out_valid appears (bounded).
  task automatic do_op(input logic [31:0] n, output int l);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_n     = n;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 0;
    while (!out_valid && l < 50) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic take_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop_after_take", 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_n = '0; out_ready = 1'b0;
`ifdef FACT_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", out_result, 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    rst = 1'b0;

    // n=5
    do_op(32'd5, lat);
    check("n5_lat", 64'(lat), 64'd4);
    check("n5_res", out_result, 64'd120);
    check("n5_ovf", 64'(out_ovf), 64'd0);
    take_result();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // n=0 and n=1: valid in the first cycle after the accept
    do_op(32'd0, lat);
    check("n0_lat", 64'(lat), 64'd0);
    check("n0_res", out_result, 64'd1);
    check("n0_ovf", 64'(out_ovf), 64'd0);
    take_result();
    do_op(32'd1, lat);
    check("n1_lat", 64'(lat), 64'd0);
    check("n1_res", out_result, 64'd1);
    check("n1_ovf", 64'(out_ovf), 64'd0);
    take_result();

    // largest exact result, then the overflow boundary
    do_op(32'd20, lat);
    check("n20_lat", 64'(lat), 64'd19);
    check("n20_res", out_result, 64'h21C3677C82B40000);
    check("n20_ovf", 64'(out_ovf), 64'd0);
    take_result();
    do_op(32'd21, lat);
    check("n21_lat", 64'(lat), 64'd20);
    check("n21_res", out_result, 64'hFFFFFFFFFFFFFFFF);
    check("n21_ovf", 64'(out_ovf), 64'd1);
    take_result();
    do_op(32'hFFFFFFFF, lat);
    check("nmax_lat", 64'(lat), 64'd20);
    check("nmax_res", out_result, 64'hFFFFFFFFFFFFFFFF);
    check("nmax_ovf", 64'(out_ovf), 64'd1);
    take_result();

    // backpressure on n=6, with a competing operand held on the input
    do_op(32'd6, lat);
    check("n6_lat", 64'(lat), 64'd5);
    in_valid = 1'b1;
    in_n     = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_res", out_result, 64'd720);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    check("bp_in_ready", 64'(in_ready), 64'd1);
    // in_valid is still high, so n=3 is accepted on this coming edge
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_busy", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_n3_lat", 64'(lat), 64'd2);
    check("bp_n3_res", out_result, 64'd6);
    take_result();

    // reset during the 3rd CALC cycle of n=10
    in_valid = 1'b1;
    in_n     = 32'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    check("rstmid_valid", 64'(out_valid), 64'd0);
    check("rstmid_res", out_result, 64'd0);
    check("rstmid_ovf", 64'(out_ovf), 64'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("rstmid_no_valid", 64'(out_valid), 64'd0);
    end
    do_op(32'd3, lat);
    check("post_rst_lat", 64'(lat), 64'd2);
    check("post_rst_res", out_result, 64'd6);
    take_result();

`ifdef FACT_ABORT_EN
    // abort on the 2nd CALC cycle of n=15
    in_valid = 1'b1;
    in_n     = 32'd15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_res_kept", out_result, 64'd6);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end
    do_op(32'd4, lat);
    check("post_abort_lat", 64'(lat), 64'd3);
    check("post_abort_res", out_result, 64'd24);
    take_result();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
